// File: rtl/led_pattern_gen.sv
// Run-time selectable LED pattern sequencer with a programmable step-rate prescaler.
// One output bit per LED; q, step and wrap are registered.
module led_pattern_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             wrap
);

  localparam logic [2:0] ModeFillL  = 3'd0;
  localparam logic [2:0] ModeFillR  = 3'd1;
  localparam logic [2:0] ModeDotL   = 3'd2;
  localparam logic [2:0] ModeDotR   = 3'd3;
  localparam logic [2:0] ModeBounce = 3'd4;
  localparam logic [2:0] ModeBlink  = 3'd5;

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [WIDTH-1:0] q_q, q_d, q_adv;
  logic [2:0]       mode_q, mode_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d, dir_adv;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick;

  function automatic logic [WIDTH-1:0] start_of(input logic [2:0] m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      ModeDotL, ModeBounce: s[0] = 1'b1;
      ModeDotR:             s[WIDTH-1] = 1'b1;
      default:              s = '0;
    endcase
    return s;
  endfunction

  // Next pattern value, assuming the current mode stays selected.
  always_comb begin
    q_adv   = q_q;
    dir_adv = dir_q;
    case (mode_q)
      ModeFillR: q_adv = (q_q == '1) ? '0 : {1'b1, q_q[WIDTH-1:1]};
      ModeDotL:  q_adv = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      ModeDotR:  q_adv = {q_q[0], q_q[WIDTH-1:1]};
      ModeBounce: begin
        if (dir_q == DirUp) begin
          q_adv = q_q << 1;
          if (q_adv[WIDTH-1]) dir_adv = DirDown;
        end else begin
          q_adv = q_q >> 1;
          if (q_adv[0]) dir_adv = DirUp;
        end
      end
      ModeBlink: q_adv = ~q_q;
      default:   q_adv = (q_q == '1) ? '0 : {q_q[WIDTH-2:0], 1'b1};
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    tick   = en && (cnt_q >= div);

    // A mode change wins over a tick on the same edge and discards it.
    if (mode != mode_q) begin
      mode_d = mode;
      q_d    = start_of(mode);
      cnt_d  = '0;
      dir_d  = DirUp;
    end else if (tick) begin
      cnt_d  = '0;
      q_d    = q_adv;
      dir_d  = dir_adv;
      step_d = 1'b1;
      wrap_d = (q_adv == start_of(mode_q)) && ((mode_q != ModeBounce) || (dir_adv == DirUp));
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      mode_q <= ModeFillL;
      cnt_q  <= '0;
      dir_q  <= DirUp;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a phase-index reference model queues expected
// outputs per cycle; a separate monitor pops and compares after each rising edge.
module tb_led_pattern_gen;

  localparam int W  = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [DW-1:0] div = '0;
  logic [W-1:0]  q;
  logic          step;
  logic          wrap;

  led_pattern_gen #(
    .WIDTH (W),
    .DIV_W (DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .div  (div),
    .q    (q),
    .step (step),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         step;
    logic         wrap;
    int           scen;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   scen = 0;
  int   cyc_no = 0;

  // Reference model: pattern described by a phase index k within the mode's period.
  int   m_mode = 0;
  int   m_k = 0;
  int   m_cnt = 0;

  function automatic int period(input int m);
    case (m)
      2, 3:    return W;
      4:       return 2 * W - 2;
      5:       return 2;
      default: return W + 1;
    endcase
  endfunction

  function automatic logic [W-1:0] pat(input int m, input int k);
    longint unsigned v;
    case (m)
      1:       v = ((64'd1 << k) - 64'd1) << (W - k);
      2:       v = 64'd1 << k;
      3:       v = 64'd1 << (W - 1 - k);
      4:       v = 64'd1 << ((k < W) ? k : (2 * W - 2 - k));
      5:       v = (k == 1) ? ((64'd1 << W) - 64'd1) : 64'd0;
      default: v = (64'd1 << k) - 64'd1;
    endcase
    return v[W-1:0];
  endfunction

  task automatic cyc(input logic r, input logic e, input int m, input int d);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = 3'(m);
    div  = DW'(d);
    x.step = 1'b0;
    x.wrap = 1'b0;
    if (r) begin
      m_mode = 0;
      m_k    = 0;
      m_cnt  = 0;
    end else if (m != m_mode) begin
      m_mode = m;
      m_k    = 0;
      m_cnt  = 0;
    end else if (e && (m_cnt >= d)) begin
      m_cnt  = 0;
      m_k    = (m_k + 1) % period(m_mode);
      x.step = 1'b1;
      x.wrap = (m_k == 0);
    end else if (e) begin
      m_cnt++;
    end
    x.q    = pat(m_mode, m_k);
    x.scen = scen;
    x.cyc  = cyc_no;
    cyc_no++;
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        total++;
        if (q !== x.q || step !== x.step || wrap !== x.wrap) begin
          bad++;
          $display("FAIL scen%0d cyc%0d: got q=%h step=%b wrap=%b, want q=%h step=%b wrap=%b",
                   x.scen, x.cyc, q, step, wrap, x.q, x.step, x.wrap);
        end
      end
    end
  end

  initial begin : driver
    int m;
    int d;
    // Reset state, then legacy fill-from-bit-0 sequence.
    scen = 1;
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 0, 0);
    repeat (20) cyc(1'b0, 1'b1, 0, 0);

    // Bounce, full periods.
    scen = 2;
    repeat (32) cyc(1'b0, 1'b1, 4, 0);

    // Dot left with div=3, enable dropped mid-count.
    scen = 3;
    repeat (10) cyc(1'b0, 1'b1, 2, 3);
    repeat (5)  cyc(1'b0, 1'b0, 2, 3);
    repeat (12) cyc(1'b0, 1'b1, 2, 3);

    // Lowering div below the running count forces an immediate tick.
    scen = 4;
    repeat (51) cyc(1'b0, 1'b1, 1, 100);
    repeat (30) cyc(1'b0, 1'b1, 1, 10);

    // Mode change on the same edge a tick is due.
    scen = 5;
    repeat (7)  cyc(1'b0, 1'b1, 0, 0);
    repeat (10) cyc(1'b0, 1'b1, 3, 0);

    // Reset out of blink at all-ones, then reserved mode 7.
    scen = 6;
    repeat (2)  cyc(1'b0, 1'b1, 5, 0);
    cyc(1'b1, 1'b1, 0, 0);
    repeat (12) cyc(1'b0, 1'b1, 0, 3);
    repeat (20) cyc(1'b0, 1'b1, 7, 0);
    repeat (6)  cyc(1'b0, 1'b1, 6, 1);

    // Randomised mix of all controls.
    scen = 7;
    m = 0;
    d = 0;
    repeat (2500) begin
      if ($urandom_range(0, 31) == 0) m = $urandom_range(0, 7);
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 40);
      else if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 3);
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), m, d);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
